// File: rtl/divisor_8bits_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock, dividend MSB first.
// Divide-by-zero is reported via ErroDiv0 with Quociente = 8'hFF and Resto = dividend.

module divisor_8bits_seq_chk (
    input logic clk_i,
    input logic rst_n_i,
    input logic calc_i,
    input logic r_msb_i
);
    // Partial remainder never exceeds 127 before it is shifted in a CALC cycle.
    a_r_msb_zero: assert property (@(posedge clk_i) disable iff (!rst_n_i) calc_i |-> !r_msb_i);
endmodule

module divisor_8bits_seq (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [7:0] Dividendo,
    input  logic [7:0] Divisor,
    output logic [7:0] Quociente,
    output logic [7:0] Resto,
    output logic       Busy,
    output logic       Done,
    output logic       ErroDiv0
);
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } state_t;

    // Divider subtractor stage: {7-bit remainder, dividend bit} - divisor; bit 8 is the borrow.
    function automatic logic [8:0] sub_stage(input logic [6:0] r_lo, input logic bit_in, input logic [7:0] d);
        sub_stage = {1'b0, r_lo, bit_in} - {1'b0, d};
    endfunction

    state_t     state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [7:0] dvs_q, dvs_d;
    logic [7:0] r_q, r_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic       dvd_bit_s;
    logic [8:0] trial_s;
    logic       q_bit_s;
    logic [7:0] r_next_s;

    // Trial subtraction for the current CALC step; restore when it borrows.
    always_comb begin
        dvd_bit_s = dvd_q[cnt_q];
        trial_s   = sub_stage(r_q[6:0], dvd_bit_s, dvs_q);
        q_bit_s   = ~trial_s[8];
        if (trial_s[8]) begin
            r_next_s = {r_q[6:0], dvd_bit_s};
        end else begin
            r_next_s = trial_s[7:0];
        end
    end

    // Next-state and registered-output logic of the OCIOSO/CALC/FIM controller.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            OCIOSO: begin
                if (Start) begin
                    dvd_d  = Dividendo;
                    dvs_d  = Divisor;
                    r_d    = 8'd0;
                    q_d    = 8'd0;
                    cnt_d  = 3'd7;
                    busy_d = 1'b1;
                    if (Divisor != 8'd0) begin
                        state_d = CALC;
                    end else begin
                        state_d = FIM;
                        quo_d   = 8'hFF;
                        rem_d   = Dividendo;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            CALC: begin
                r_d    = r_next_s;
                q_d    = {q_q[6:0], q_bit_s};
                busy_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = FIM;
                    quo_d   = {q_q[6:0], q_bit_s};
                    rem_d   = r_next_s;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            FIM: begin
                state_d = OCIOSO;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = OCIOSO;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by Reset_n.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= OCIOSO;
            dvd_q   <= 8'd0;
            dvs_q   <= 8'd0;
            r_q     <= 8'd0;
            q_q     <= 8'd0;
            cnt_q   <= 3'd0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Quociente = quo_q;
    assign Resto     = rem_q;
    assign ErroDiv0  = err_q;
    assign Done      = done_q;
    assign Busy      = busy_q;

    divisor_8bits_seq_chk u_chk (
        .clk_i   (Clock),
        .rst_n_i (Reset_n),
        .calc_i  (state_q == CALC),
        .r_msb_i (r_q[7])
    );
endmodule

// File: tb/tb_divisor_8bits_seq.sv
// Directed bench for divisor_8bits_seq: latency, results, div-by-zero, ignored Start,
// mid-operation reset, back-to-back operation and a small random sweep.
module tb_divisor_8bits_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       busy;
    logic       done;
    logic       err;
    int checks   = 0;
    int failures = 0;

    divisor_8bits_seq dut (
        .Clock     (clk),
        .Reset_n   (rst_n),
        .Start     (start),
        .Dividendo (dvd),
        .Divisor   (dvs),
        .Quociente (quo),
        .Resto     (rem),
        .Busy      (busy),
        .Done      (done),
        .ErroDiv0  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from an idle negedge; sample n negedges after the accepting edge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int done_n, output int busy_n,
                         output int done_cnt, output logic [7:0] q, output logic [7:0] r, output logic e);
        done_n = 0; busy_n = 0; done_cnt = 0; q = 8'd0; r = 8'd0; e = 1'b0;
        dvd = a; dvs = b; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin start = 1'b0; dvd = ~a; dvs = b + 8'd1; end
            if (busy) busy_n++;
            if (done) begin
                done_cnt++;
                if (done_n == 0) begin done_n = n; q = quo; r = rem; e = err; end
            end
            if (done_n != 0 && !busy) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dvd = 8'd0; dvs = 8'd0;
        #2;
        checks++; if ({quo, rem, busy, done, err} !== 19'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {quo, rem, busy, done, err}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_idle got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_basic();
        int dn, bn, dc; logic [7:0] q, r; logic e;
        do_op(8'd200, 8'd7, dn, bn, dc, q, r, e);
        checks++; if (dn !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", dn); end
        checks++; if (q !== 8'd28) begin failures++; $display("FAIL basic_q got=%0d exp=28", q); end
        checks++; if (r !== 8'd4) begin failures++; $display("FAIL basic_r got=%0d exp=4", r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_err got=%0d exp=0", e); end
        checks++; if (bn !== 9) begin failures++; $display("FAIL basic_busy got=%0d exp=9", bn); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", dc); end
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'd255, 8'd255, 8'd5, 8'd250};
        logic [7:0] vb [4] = '{8'd1, 8'd255, 8'd9, 8'd129};
        logic [7:0] vq [4] = '{8'd255, 8'd1, 8'd0, 8'd1};
        logic [7:0] vr [4] = '{8'd0, 8'd0, 8'd5, 8'd121};
        int dn, bn, dc; logic [7:0] q, r; logic e;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], dn, bn, dc, q, r, e);
            checks++; if (q !== vq[i]) begin failures++; $display("FAIL vec%0d_q got=%0d exp=%0d", i, q, vq[i]); end
            checks++; if (r !== vr[i]) begin failures++; $display("FAIL vec%0d_r got=%0d exp=%0d", i, r, vr[i]); end
            checks++; if (bn !== 9) begin failures++; $display("FAIL vec%0d_busy got=%0d exp=9", i, bn); end
            checks++; if (dn !== 9) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=9", i, dn); end
        end
    endtask

    task automatic test_div0();
        int dn, bn, dc; logic [7:0] q, r; logic e;
        do_op(8'd13, 8'd0, dn, bn, dc, q, r, e);
        checks++; if (dn !== 1) begin failures++; $display("FAIL div0_latency got=%0d exp=1", dn); end
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL div0_q got=%0d exp=255", q); end
        checks++; if (r !== 8'd13) begin failures++; $display("FAIL div0_r got=%0d exp=13", r); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL div0_err got=%0d exp=1", e); end
        checks++; if (bn !== 1) begin failures++; $display("FAIL div0_busy got=%0d exp=1", bn); end
        do_op(8'd100, 8'd10, dn, bn, dc, q, r, e);
        checks++; if ({q, r} !== {8'd10, 8'd0}) begin failures++; $display("FAIL after_div0_qr got=%0d,%0d exp=10,0", q, r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL after_div0_err got=%0d exp=0", e); end
    endtask

    task automatic test_ignore_start();
        int dn = 0; int dc = 0; logic [7:0] q = 8'd0; logic [7:0] r = 8'd0;
        dvd = 8'd200; dvs = 8'd7; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 4) begin start = 1'b1; dvd = 8'd50; dvs = 8'd3; end
            if (n == 5) start = 1'b0;
            if (n == 6) begin
                checks++; if ({quo, rem, err} !== {8'd10, 8'd0, 1'b0}) begin failures++; $display("FAIL hold_during_calc got=%0d,%0d,%0d exp=10,0,0", quo, rem, err); end
            end
            if (done) begin dc++; if (dn == 0) begin dn = n; q = quo; r = rem; end end
            if (dn != 0 && !busy) break;
        end
        checks++; if ({q, r} !== {8'd28, 8'd4}) begin failures++; $display("FAIL ignore_start_qr got=%0d,%0d exp=28,4", q, r); end
        checks++; if (dn !== 9 || dc !== 1) begin failures++; $display("FAIL ignore_start_done got=n%0d,c%0d exp=n9,c1", dn, dc); end
    endtask

    task automatic test_reset_mid();
        int dn, bn, dc; logic [7:0] q, r; logic e;
        int stray = 0;
        dvd = 8'd250; dvs = 8'd129; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({quo, rem, busy, done, err} !== 19'd0) begin failures++; $display("FAIL reset_mid_async got=%h exp=0", {quo, rem, busy, done, err}); end
        @(negedge clk); rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", stray); end
        do_op(8'd77, 8'd6, dn, bn, dc, q, r, e);
        checks++; if ({q, r} !== {8'd12, 8'd5}) begin failures++; $display("FAIL post_reset_qr got=%0d,%0d exp=12,5", q, r); end
        checks++; if (dn !== 9) begin failures++; $display("FAIL post_reset_latency got=%0d exp=9", dn); end
    endtask

    task automatic test_back_to_back();
        int d1 = 0; int d2 = 0; logic [7:0] q1 = 8'd0; logic [7:0] r1 = 8'd0;
        logic [7:0] q2 = 8'd0; logic [7:0] r2 = 8'd0; logic idle_gap = 1'b1;
        dvd = 8'd60; dvs = 8'd7; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (n == 1) begin dvd = 8'd9; dvs = 8'd2; end
            if (n == 10) idle_gap = busy;
            if (done) begin
                if (d1 == 0) begin d1 = n; q1 = quo; r1 = rem; end
                else if (d2 == 0) begin d2 = n; q2 = quo; r2 = rem; start = 1'b0; end
            end
        end
        start = 1'b0;
        checks++; if ({q1, r1} !== {8'd8, 8'd4} || d1 !== 9) begin failures++; $display("FAIL b2b_first got=%0d,%0d@%0d exp=8,4@9", q1, r1, d1); end
        checks++; if (idle_gap !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=0", idle_gap); end
        checks++; if ({q2, r2} !== {8'd4, 8'd1} || d2 !== 19) begin failures++; $display("FAIL b2b_second got=%0d,%0d@%0d exp=4,1@19", q2, r2, d2); end
    endtask

    task automatic test_sweep();
        logic [7:0] ca [5] = '{8'd0, 8'd0, 8'd128, 8'd127, 8'd254};
        logic [7:0] cb [5] = '{8'd1, 8'd255, 8'd128, 8'd128, 8'd255};
        int dn, bn, dc; logic [7:0] q, r; logic e;
        logic [7:0] a, b;
        int bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (i < 5) begin a = ca[i]; b = cb[i]; end
            else begin a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(1, 255)); end
            do_op(a, b, dn, bn, dc, q, r, e);
            checks++;
            if (q !== a / b || r !== a % b || (int'(q) * int'(b) + int'(r)) != int'(a) || r >= b || e !== 1'b0 || dn !== 9) begin
                failures++; bad++;
                $display("FAIL sweep %0d/%0d got=q%0d,r%0d,e%0d@%0d exp=q%0d,r%0d,e0@9", a, b, q, r, e, dn, a / b, a % b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div0();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divisor_8bits_seq.md
DIVISOR_8BITS_SEQ -- requirements
Module: divisor_8bits_seq

Interface
REQ-001 SHALL provide: Clock  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: Reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: Start  input  1  request to begin a division; sampled on the rising edge of Clock.
REQ-004 SHALL provide: Dividendo  input  8  unsigned dividend; captured when Start is accepted.
REQ-005 SHALL provide: Divisor  input  8  unsigned divisor; captured when Start is accepted.
REQ-006 SHALL provide: Quociente  output  8  unsigned quotient of the last completed operation.
REQ-007 SHALL provide: Resto  output  8  unsigned remainder of the last completed operation.
REQ-008 SHALL provide: Busy  output  1  high while an operation is in progress (states CALC and FIM).
REQ-009 SHALL provide: Done  output  1  one-cycle pulse; Quociente, Resto and ErroDiv0 are valid in that cycle.
REQ-010 SHALL provide: ErroDiv0  output  1  high when the last completed operation had Divisor = 0.

Function
REQ-011 SHALL implement a restoring divider, one quotient bit per clock, MSB of the dividend first.
REQ-012 SHALL use an FSM with three states: OCIOSO (idle), CALC, FIM.
REQ-013 SHALL accept Start only in OCIOSO; Start in any other state SHALL be ignored.
REQ-014 Transition on Start in OCIOSO: capture operands, clear partial remainder R[7:0] and quotient shift register, load iteration counter = 7.
REQ-015 With Divisor != 0, next state SHALL be CALC; with Divisor = 0, next state SHALL be FIM directly.
REQ-016 Each CALC cycle SHALL form the trial difference {R[6:0], dividend bit[counter]} - Divisor, giving S[7:0] and borrow Bout, using the team's 8-bit divider subtractor stage (7-bit remainder + 1 dividend bit minus 8-bit divisor).
REQ-017 Quotient bit SHALL be ~Bout; R SHALL become S when Bout = 0, else {R[6:0], dividend bit}.
REQ-018 Before each shift R[7] is always 0 (R < Divisor and R <= 127 after at most 7 bits); an assertion SHALL check this every CALC cycle.
REQ-019 CALC SHALL run exactly 8 cycles, counter 7 down to 0; after counter = 0, next state SHALL be FIM.
REQ-020 On entry to FIM, Quociente/Resto/ErroDiv0 SHALL update; Done SHALL be high for exactly the FIM cycle; next state SHALL be OCIOSO.
REQ-021 Latency: Done SHALL assert 9 cycles after the accepting edge (Divisor != 0) and 1 cycle after it (Divisor = 0).
REQ-022 Divide-by-zero SHALL give Quociente = 8'hFF, Resto = captured Dividendo, ErroDiv0 = 1.
REQ-023 A normal completion SHALL clear ErroDiv0.
REQ-024 Quociente, Resto and ErroDiv0 SHALL hold their previous values during CALC and until the next FIM.
REQ-025 Input changes after acceptance SHALL have no effect on the running operation.
REQ-026 Start held high through FIM SHALL be accepted on the first OCIOSO edge (back-to-back operations, one idle cycle between them).

Reset
REQ-027 Reset_n low SHALL immediately, without a clock, force state OCIOSO and set Quociente = 0, Resto = 0, Busy = 0, Done = 0, ErroDiv0 = 0, and clear all internal registers.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no Done pulse; the first Start after release SHALL behave as from power-up.

Verification
REQ-029 Dividendo = 200, Divisor = 7, Start = 1 -> Done 9 cycles later, Quociente = 28, Resto = 4, ErroDiv0 = 0.
REQ-030 255/1 -> 255, 0; 255/255 -> 1, 0; 5/9 -> 0, 5; 250/129 -> 1, 121; Busy high for exactly 9 cycles each.
REQ-031 13/0 -> Done 1 cycle later, Quociente = 8'hFF, Resto = 13, ErroDiv0 = 1; then 100/10 -> 10, 0 with ErroDiv0 cleared.
REQ-032 Start pulsed during CALC with different operands -> ignored; the original result is delivered unchanged.
REQ-033 Reset_n pulsed low at CALC cycle 4 -> outputs 0 asynchronously, no Done; a subsequent 77/6 -> 12, 5.
REQ-034 Random sweep of all Dividendo/Divisor pairs with Divisor != 0 -> Quociente*Divisor + Resto = Dividendo and Resto < Divisor; the R[7] assertion never fires.
